// File: rtl/tour_cmd.sv
// Tour command sequencer: passes UART commands through while idle, otherwise expands each
// one-hot knight move into a vertical then a horizontal move command for cmd_proc.
module tour_cmd #(
  parameter int unsigned NUM_MOVES = 24,
  parameter int unsigned IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp
);

  localparam logic [7:0] HeadNorth = 8'h00;
  localparam logic [7:0] HeadWest  = 8'h3F;
  localparam logic [7:0] HeadSouth = 8'h7F;
  localparam logic [7:0] HeadEast  = 8'hBF;

  localparam logic [7:0] RespFinal = 8'hA5;
  localparam logic [7:0] RespInter = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StVert,
    StWaitV,
    StHorz,
    StWaitH
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_move;

  logic [7:0]       move_sel;
  logic [7:0]       v_head;
  logic [3:0]       v_sq;
  logic [7:0]       h_head;
  logic [3:0]       h_sq;
  logic [15:0]      vert_cmd;
  logic [15:0]      horz_cmd;

  assign mv_indx   = idx_q;
  assign last_move = (idx_q == IDX_W'(NUM_MOVES - 1));

  // Isolate the lowest set bit so a corrupted multi-bit move still decodes deterministically.
  assign move_sel = move & (~move + 8'd1);

  always_comb begin
    v_head = HeadNorth;
    v_sq   = 4'd0;
    h_head = HeadEast;
    h_sq   = 4'd0;
    case (move_sel)
      8'h01: begin v_head = HeadNorth; v_sq = 4'd2; h_head = HeadEast; h_sq = 4'd1; end
      8'h02: begin v_head = HeadNorth; v_sq = 4'd2; h_head = HeadWest; h_sq = 4'd1; end
      8'h04: begin v_head = HeadNorth; v_sq = 4'd1; h_head = HeadWest; h_sq = 4'd2; end
      8'h08: begin v_head = HeadSouth; v_sq = 4'd1; h_head = HeadWest; h_sq = 4'd2; end
      8'h10: begin v_head = HeadSouth; v_sq = 4'd2; h_head = HeadWest; h_sq = 4'd1; end
      8'h20: begin v_head = HeadSouth; v_sq = 4'd2; h_head = HeadEast; h_sq = 4'd1; end
      8'h40: begin v_head = HeadSouth; v_sq = 4'd1; h_head = HeadEast; h_sq = 4'd2; end
      8'h80: begin v_head = HeadNorth; v_sq = 4'd1; h_head = HeadEast; h_sq = 4'd2; end
      default: ;
    endcase
  end

  assign vert_cmd = {3'b001, 1'b0, v_head, v_sq};
  assign horz_cmd = {3'b001, 1'b1, h_head, h_sq};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_tour) begin
            state_q <= StVert;
            idx_q   <= '0;
          end
        end
        StVert: begin
          // An empty move slot means the solver had no tour; abandon without issuing anything.
          if (move == 8'h00) begin
            state_q <= StIdle;
            idx_q   <= '0;
          end else if (clr_cmd_rdy) begin
            state_q <= StWaitV;
          end
        end
        StWaitV: begin
          if (send_resp) state_q <= StHorz;
        end
        StHorz: begin
          if (clr_cmd_rdy) state_q <= StWaitH;
        end
        StWaitH: begin
          if (send_resp) begin
            if (last_move) begin
              state_q <= StIdle;
              idx_q   <= '0;
            end else begin
              state_q <= StVert;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          idx_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RespInter;
    unique case (state_q)
      StIdle: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RespFinal;
      end
      StVert: begin
        cmd     = vert_cmd;
        cmd_rdy = (move != 8'h00);
      end
      StWaitV: begin
        cmd = vert_cmd;
      end
      StHorz: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      StWaitH: begin
        cmd  = horz_cmd;
        resp = last_move ? RespFinal : RespInter;
      end
      default: ;
    endcase
  end

endmodule
